// File: rtl/gamepad_pkg.sv
// Shared definitions for the serial gamepad reader: FSM encoding, button indices, defaults
// and the contradictory-direction cleanup.
package gamepad_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_LOW,
      ST_HIGH,
      ST_DONE
   } state_t;

   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

   localparam int unsigned DEF_CLK_DIV     = 4;
   localparam int unsigned DEF_POLL_PERIOD = 1000;

   // Opposite directions pressed together are both reported released.
   function automatic logic [7:0] clean_dirs(input logic [7:0] b);
      logic [7:0] r;
      r = b;
      if (b[BTN_UP] && b[BTN_DOWN]) begin
         r[BTN_UP]   = 1'b0;
         r[BTN_DOWN] = 1'b0;
      end
      if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
         r[BTN_LEFT]  = 1'b0;
         r[BTN_RIGHT] = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/gamepad_if.sv
// Controller-side wires of the latch/clock/data shift protocol.
interface gamepad_if;
   logic pad_data;
   logic pad_latch;
   logic pad_clk;

   modport master (input pad_data, output pad_latch, output pad_clk);
   modport slave  (output pad_data, input pad_latch, input pad_clk);
endinterface

// File: rtl/pad_sync.sv
// Two-flop synchroniser for the asynchronous pad data line; resets to released (1).
module pad_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/gamepad_reader.sv
// NES-style gamepad poller: latches, shifts in eight active-low bits and presents cleaned,
// registered button levels. Define GAMEPAD_PRESS_EN to enable the new-press pulse output.
module gamepad_reader
   import gamepad_pkg::*;
#(
   parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
   parameter int unsigned POLL_PERIOD = DEF_POLL_PERIOD
) (
   input  logic        clk,
   input  logic        reset,
   gamepad_if.master   pad,
   output logic        A,
   output logic        B,
   output logic        select,
   output logic        start,
   output logic        up,
   output logic        down,
   output logic        left,
   output logic        right,
   output logic        frame_valid,
   output logic [7:0]  press
);

   localparam int unsigned TICK_W = $clog2(2 * CLK_DIV);
   localparam int unsigned POLL_W = $clog2(POLL_PERIOD + 1);

   state_t              state;
   logic [TICK_W-1:0]   tick;
   logic [POLL_W-1:0]   poll_cnt;
   logic [2:0]          idx;
   logic [7:0]          shift_q;
   logic [7:0]          btn_q;
   logic [7:0]          cleaned;
   logic                data_s;
   logic                latch_q;
   logic                pclk_q;

   pad_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pad.pad_data),
      .q     (data_s)
   );

   always_comb cleaned = clean_dirs(shift_q);

`ifdef GAMEPAD_PRESS_EN
   logic [7:0] prev_q;
   logic [7:0] press_q;
   assign press = press_q;
`else
   assign press = 8'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         tick        <= '0;
         poll_cnt    <= '0;
         idx         <= 3'd0;
         shift_q     <= 8'b0;
         btn_q       <= 8'b0;
         latch_q     <= 1'b0;
         pclk_q      <= 1'b0;
         frame_valid <= 1'b0;
`ifdef GAMEPAD_PRESS_EN
         prev_q      <= 8'b0;
         press_q     <= 8'b0;
`endif
      end else begin
         frame_valid <= 1'b0;
`ifdef GAMEPAD_PRESS_EN
         press_q     <= 8'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (poll_cnt == POLL_W'(POLL_PERIOD - 1)) begin
                  state    <= ST_LATCH;
                  poll_cnt <= '0;
                  tick     <= '0;
                  latch_q  <= 1'b1;
               end else begin
                  poll_cnt <= poll_cnt + 1'b1;
               end
            end
            ST_LATCH: begin
               if (tick == TICK_W'(2 * CLK_DIV - 1)) begin
                  state   <= ST_LOW;
                  tick    <= '0;
                  idx     <= 3'd0;
                  latch_q <= 1'b0;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            ST_LOW: begin
               // Sample late in the low phase so the synchroniser has settled.
               if (tick == TICK_W'(CLK_DIV - 1)) begin
                  shift_q[idx] <= ~data_s;
                  tick         <= '0;
                  if (idx == 3'd7) begin
                     state <= ST_DONE;
                  end else begin
                     state  <= ST_HIGH;
                     pclk_q <= 1'b1;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            ST_HIGH: begin
               if (tick == TICK_W'(CLK_DIV - 1)) begin
                  state  <= ST_LOW;
                  tick   <= '0;
                  idx    <= idx + 3'd1;
                  pclk_q <= 1'b0;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            ST_DONE: begin
               btn_q       <= cleaned;
               frame_valid <= 1'b1;
`ifdef GAMEPAD_PRESS_EN
               press_q     <= cleaned & ~prev_q;
               prev_q      <= cleaned;
`endif
               state       <= ST_IDLE;
               poll_cnt    <= '0;
               tick        <= '0;
            end
            default: begin
               state    <= ST_IDLE;
               poll_cnt <= '0;
               tick     <= '0;
            end
         endcase
      end
   end

   assign pad.pad_latch = latch_q;
   assign pad.pad_clk   = pclk_q;

   assign A      = btn_q[BTN_A];
   assign B      = btn_q[BTN_B];
   assign select = btn_q[BTN_SELECT];
   assign start  = btn_q[BTN_START];
   assign up     = btn_q[BTN_UP];
   assign down   = btn_q[BTN_DOWN];
   assign left   = btn_q[BTN_LEFT];
   assign right  = btn_q[BTN_RIGHT];

endmodule
